// File: rtl/cascade_counter_if.sv
// Control/status bundle for cascade_counter.
//   master: drives en, up, clr, load, load_val; observes count, tc, carry_out, wrapped
//   slave : the counter itself (opposite directions)
interface cascade_counter_if #(
  parameter int unsigned W      = 4,
  parameter int unsigned STAGES = 3
);
  logic                  en;
  logic                  up;
  logic                  clr;
  logic                  load;
  logic [STAGES*W-1:0]   load_val;
  logic [STAGES*W-1:0]   count;
  logic [STAGES-1:0]     tc;
  logic                  carry_out;
  logic                  wrapped;

  modport master (
    output en, up, clr, load, load_val,
    input  count, tc, carry_out, wrapped
  );

  modport slave (
    input  en, up, clr, load, load_val,
    output count, tc, carry_out, wrapped
  );
endinterface

// File: rtl/cascade_counter.sv
// Cascadable multi-stage modulo counter (digit engine for timers/displays).
// Each stage i counts modulo MODS[i*W +: W] (field 0 means 2^W), stage 0 is
// least significant. Supports up/down, parallel load with saturation,
// synchronous clear, per-stage terminal-count flags (combinational tc),
// a one-cycle carry_out pulse after a full-chain wrap and a sticky wrapped flag.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - cascade_counter_if slave modport (en, up, clr, load, load_val in;
//          count, tc, carry_out, wrapped out)
module cascade_counter #(
  parameter int unsigned         W      = 4,
  parameter int unsigned         STAGES = 3,
  parameter logic [STAGES*W-1:0] MODS   = {4'd6, 4'd10, 4'd10}
) (
  input logic              clk,
  input logic              rst,
  cascade_counter_if.slave bus
);

  localparam int unsigned CW = STAGES * W;

  logic [CW-1:0]     cnt_q;
  logic              carry_q;
  logic              wrapped_q;
  logic [STAGES-1:0] tc_c;
  logic [STAGES:0]   step_c;      // step_c[i]: all lower stages at terminal value
  logic [CW-1:0]     step_val_c;  // next count when en is honoured
  logic [CW-1:0]     load_sat_c;  // load_val clamped per stage
  logic              wrap_c;

  assign step_c[0] = 1'b1;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    // Field value 0 underflows to all-ones, which is exactly 2^W - 1.
    localparam logic [W-1:0] MAXV = MODS[i*W +: W] - W'(1);

    logic [W-1:0] cur;
    logic [W-1:0] nxt;
    logic [W-1:0] lv;

    assign cur = cnt_q[i*W +: W];
    assign lv  = bus.load_val[i*W +: W];

    assign tc_c[i]     = bus.up ? (cur == MAXV) : (cur == '0);
    assign step_c[i+1] = step_c[i] & tc_c[i];

    // Per-stage modulo step, only when every lower stage is terminal.
    always_comb begin
      nxt = cur;
      if (step_c[i]) begin
        if (bus.up) nxt = (cur == MAXV) ? '0 : cur + W'(1);
        else        nxt = (cur == '0) ? MAXV : cur - W'(1);
      end
    end

    assign step_val_c[i*W +: W] = nxt;
    assign load_sat_c[i*W +: W] = (lv > MAXV) ? MAXV : lv;
  end

  assign wrap_c = bus.en & step_c[STAGES];

  // State update: clr > load > en > hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      wrapped_q <= 1'b0;
    end else if (bus.clr) begin
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      wrapped_q <= 1'b0;
    end else if (bus.load) begin
      cnt_q   <= load_sat_c;
      carry_q <= 1'b0;
    end else if (bus.en) begin
      cnt_q   <= step_val_c;
      carry_q <= wrap_c;
      if (wrap_c) wrapped_q <= 1'b1;
    end else begin
      carry_q <= 1'b0;
    end
  end

  assign bus.count     = cnt_q;
  assign bus.tc        = tc_c;
  assign bus.carry_out = carry_q;
  assign bus.wrapped   = wrapped_q;

endmodule

// File: tb/tb_cascade_counter.sv
// Scoreboard bench for cascade_counter with default parameters (mod 10/10/6).
module tb_cascade_counter;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  cascade_counter_if #(.W(4), .STAGES(3)) bus ();

  cascade_counter #(
    .W(4), .STAGES(3), .MODS(12'h6AA)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [11:0] cnt;
    logic        co;
    logic        wr;
  } exp_t;

  exp_t sb[$];

  int total = 0;
  int bad   = 0;
  int pulses;

  // Reference model: digit values and moduli, carry-propagation stepping.
  int   m[3] = '{10, 10, 6};
  int   d[3];
  logic mco;
  logic mwr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] model_count();
    logic [11:0] r;
    for (int i = 0; i < 3; i++) r[i*4 +: 4] = 4'(d[i]);
    return r;
  endfunction

  function automatic logic [2:0] model_tc(input logic u);
    logic [2:0] r;
    for (int i = 0; i < 3; i++) r[i] = u ? (d[i] == m[i] - 1) : (d[i] == 0);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) d[i] = 0;
    mco = 1'b0;
    mwr = 1'b0;
  endtask

  task automatic model_next(input logic en_i, input logic up_i, input logic clr_i,
                            input logic load_i, input logic [11:0] lv);
    int  v;
    logic go;
    if (clr_i) begin
      for (int i = 0; i < 3; i++) d[i] = 0;
      mco = 1'b0;
      mwr = 1'b0;
    end else if (load_i) begin
      for (int i = 0; i < 3; i++) begin
        v    = int'(lv[i*4 +: 4]);
        d[i] = (v >= m[i]) ? m[i] - 1 : v;
      end
      mco = 1'b0;
    end else if (en_i) begin
      go = 1'b1;
      for (int i = 0; i < 3; i++) begin
        if (go) begin
          if (up_i) begin
            if (d[i] == m[i] - 1) d[i] = 0;
            else begin d[i] = d[i] + 1; go = 1'b0; end
          end else begin
            if (d[i] == 0) d[i] = m[i] - 1;
            else begin d[i] = d[i] - 1; go = 1'b0; end
          end
        end
      end
      mco = go;
      if (go) mwr = 1'b1;
    end else begin
      mco = 1'b0;
    end
  endtask

  // One clock: drive, check tc pre-edge, push expectation, edge, pop and compare.
  task automatic step(input logic en_i, input logic up_i, input logic clr_i,
                      input logic load_i, input logic [11:0] lv);
    exp_t e;
    bus.en       = en_i;
    bus.up       = up_i;
    bus.clr      = clr_i;
    bus.load     = load_i;
    bus.load_val = lv;
    #1;
    check("tc", 32'(bus.tc), 32'(model_tc(up_i)));
    model_next(en_i, up_i, clr_i, load_i, lv);
    e.cnt = model_count();
    e.co  = mco;
    e.wr  = mwr;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 32'(1), 32'(0));
    end else begin
      e = sb.pop_front();
      check("count", 32'(bus.count), 32'(e.cnt));
      check("carry_out", 32'(bus.carry_out), 32'(e.co));
      check("wrapped", 32'(bus.wrapped), 32'(e.wr));
    end
    if (bus.carry_out) pulses++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    bus.en       = 1'b0;
    bus.up       = 1'b1;
    bus.clr      = 1'b0;
    bus.load     = 1'b0;
    bus.load_val = '0;
    model_reset();

    // Reset state and tc under both directions.
    #2;
    check("rst_count", 32'(bus.count), 32'(0));
    check("rst_carry", 32'(bus.carry_out), 32'(0));
    check("rst_wrapped", 32'(bus.wrapped), 32'(0));
    check("rst_tc_up", 32'(bus.tc), 32'(3'b000));
    bus.up = 1'b0;
    #1;
    check("rst_tc_down", 32'(bus.tc), 32'(3'b111));
    bus.up = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Full 000..599 run and wrap back to 000.
    pulses = 0;
    for (int i = 0; i < 600; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
    check("up_wrap_count", 32'(bus.count), 32'(12'h000));
    check("up_wrap_pulses", 32'(pulses), 32'(1));
    step(1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
    check("wrapped_sticky", 32'(bus.wrapped), 32'(1));

    // Stage ripple from 099.
    step(1'b0, 1'b1, 1'b0, 1'b1, 12'h099);
    check("ripple_tc", 32'(bus.tc), 32'(3'b011));
    step(1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
    check("ripple_count", 32'(bus.count), 32'(12'h100));

    // Count-down wrap.
    step(1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
    step(1'b1, 1'b0, 1'b0, 1'b0, 12'h000);
    check("down_wrap", 32'(bus.count), 32'(12'h599));
    check("down_wrap_co", 32'(bus.carry_out), 32'(1));
    step(1'b1, 1'b0, 1'b0, 1'b0, 12'h000);
    check("down_598", 32'(bus.count), 32'(12'h598));

    // Async reset between edges at 347.
    step(1'b0, 1'b1, 1'b0, 1'b1, 12'h347);
    bus.en   = 1'b1;
    bus.up   = 1'b1;
    bus.load = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("async_count", 32'(bus.count), 32'(0));
    check("async_carry", 32'(bus.carry_out), 32'(0));
    check("async_wrapped", 32'(bus.wrapped), 32'(0));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rst_hold", 32'(bus.count), 32'(0));
    end
    rst = 1'b0;
    model_reset();

    // Load saturation, then clr+load+en together.
    step(1'b0, 1'b1, 1'b0, 1'b1, 12'hF0C);
    check("load_sat", 32'(bus.count), 32'(12'h509));
    step(1'b1, 1'b1, 1'b1, 1'b1, 12'h123);
    check("clr_prio", 32'(bus.count), 32'(12'h000));
    // load+en: load wins, no step.
    step(1'b1, 1'b1, 1'b0, 1'b1, 12'h599);
    check("load_over_en", 32'(bus.count), 32'(12'h599));

    // Direction flip then hold with up toggling.
    step(1'b0, 1'b1, 1'b0, 1'b1, 12'h123);
    step(1'b1, 1'b0, 1'b0, 1'b0, 12'h000);
    check("flip_down", 32'(bus.count), 32'(12'h122));
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 12'h000);
    check("hold_count", 32'(bus.count), 32'(12'h122));
    step(1'b0, 1'b1, 1'b0, 1'b1, 12'h500);
    for (int i = 0; i < 4; i++) step(1'b0, logic'(i % 2), 1'b0, 1'b0, 12'h000);
    bus.up = 1'b0;
    #1;
    check("tc_down_500", 32'(bus.tc), 32'(3'b011));
    bus.up = 1'b1;
    #1;
    check("tc_up_500", 32'(bus.tc), 32'(3'b100));

    // Random controls against the model.
    for (int i = 0; i < 300; i++) begin
      step(logic'(($urandom % 4) != 0), logic'($urandom % 2),
           logic'(($urandom % 40) == 0), logic'(($urandom % 16) == 0),
           12'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cascade_counter.md
# cascade_counter

Parametrised, cascadable multi-stage modulo counter. It generalises the team's single mod-n binary counter to STAGES digits, each with its own modulus, plus up/down counting, parallel load, synchronous clear, per-stage terminal-count flags and a registered wrap pulse. It is the common timebase/digit engine for display and timer blocks, e.g. mod-10/mod-10/mod-6 for a 000-599 seconds counter.

## Interface
- W, 4, bit width of each stage.
- STAGES, 3, number of cascaded stages; stage 0 is least significant.
- MODS, {4'd6,4'd10,4'd10}, packed STAGES*W moduli; stage i uses MODS[i*W +: W]; field value 0 encodes 2^W; legal values 2..2^W.
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- en  input  1  count enable; one step per enabled cycle.
- up  input  1  direction: 1 = up, 0 = down.
- clr  input  1  synchronous clear of all stages to 0.
- load  input  1  synchronous parallel load.
- load_val  input  STAGES*W  load data, same packing as count.
- count  output  STAGES*W  registered stage values, stage i at count[i*W +: W].
- tc  output  STAGES  combinational; tc[i]=1 when stage i sits at its terminal value for the current direction.
- carry_out  output  1  registered one-cycle pulse after a full-chain wrap.
- wrapped  output  1  sticky flag, set by any full-chain wrap, cleared by clr or rst.

## Operation
- Let M_i = modulus of stage i. Terminal value T_i = M_i-1 when up=1, 0 when up=0.
- tc[i] = (count_i == T_i), driven from count and up with no register.
- Priority per cycle: clr > load > en > hold.
- clr: all stages <= 0, carry_out <= 0, wrapped <= 0.
- load: stage i <= load_val_i if load_val_i < M_i, otherwise M_i-1 (saturate). carry_out <= 0; wrapped is unchanged.
- en with no clr/load:
  - Stage 0 always steps.
  - Stage i>0 steps only when tc[0..i-1] are all 1 (ripple enable, evaluated on pre-edge values).
  - Step up: T_i -> 0, otherwise +1. Step down: 0 -> M_i-1, otherwise -1.
- Full-chain wrap: en=1 and all tc bits are 1 in the same cycle. Next edge: every stage wraps, carry_out <= 1 and wrapped <= 1.
- carry_out is 0 in every cycle that is not directly after a wrap edge.
- en=0: count holds and carry_out <= 0.
- up may change in any cycle; the new direction takes effect at the next edge, and tc reflects it immediately.
- Arithmetic is modulo M_i per stage; count_i never leaves 0..M_i-1.
- With M_i = 2^W (field 0), the natural W-bit wrap applies.

## Timing
- rst asserted: count = 0, carry_out = 0, wrapped = 0 immediately, independent of clk. tc follows from count=0: tc = all 1 when up=0, all 0 when up=1 (for M_i > 1).
- rst deasserted: the first enabled edge produces count = 1 (up) or all stages = M_i-1 (down).
- Latency: one clk from en/clr/load sample to count update. carry_out asserts in the same cycle that count shows the wrapped value.
- rst mid-operation overrides any in-progress load/clr/en. No partial update remains visible.
- Simultaneous clr+load+en: clear wins. load+en: load wins, no step, no carry.

## Test plan
- Reset and count-up, default params: rst pulse, en=1, up=1 for 600 cycles -> count runs 000..599, then 000. carry_out is high exactly once, in the cycle count=000 after 599. wrapped=1 from then on.
- Stage ripple: load 0x099 (digits 0,9,9), en=1, up=1 -> next count = 0x100. tc = 3'b011 before the edge.
- Count-down wrap: clr, then en=1, up=0 -> next count = 0x599 with carry_out=1. Next count = 0x598 with carry_out=0.
- Load saturation and priority: load_val = 0xF0C, load=1 -> count = 0x509. Then load=1, clr=1, en=1 together -> count=000, wrapped=0, carry_out=0.
- Async reset mid-run: at count=0x347 with en=1, assert rst between edges -> count=000, carry_out=0, wrapped=0 before the next edge. Hold for 3 edges -> count stays 000.
- Direction flip and hold: at 0x123, up=0 for 1 cycle -> 0x122. Then up=1, en=0 for 5 cycles -> count holds 0x122 and tc tracks up.
